vce_palette_loader: RTL and testbench
=====================================

# vce_palette_loader

Bus-master initiator for the HuC6260 VCE's CPU-side MMIO port. On a start pulse, it reads a palette from a synchronous source memory and writes it into VCE colour RAM through the normal register sequence: CTA low, CTA high, then CTW low/high per entry, relying on the VCE's auto-increment. It sits beside the CPU on the VCE bus and gains access through a simple request/grant arbiter. It replaces ad-hoc CRAM preloading for bring-up and boot.

## Interface
- `STROBE_CYCLES`, default 6: master clocks `WR_n` is held low, and then held high, per write. Legal range is ≥3, so each phase spans at least one VCE MMIO (clock/3) enable.
- `NUM_ENTRIES`, default 512: palette entries to transfer, range 1..512.
- `START_ADDR`, default 9'h000: first CRAM index written to CTA.
- `clock`  in  1: master clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle request to begin a load.
- `busy`  out  1: high from the accepted start until `done`.
- `done`  out  1: one-cycle pulse after the final write's recovery phase.
- `bus_req`  out  1: high while `busy`.
- `bus_gnt`  in  1: arbiter grant. A write begins only while it is high.
- `src_addr`  out  9: source palette index, counting 0..NUM_ENTRIES-1.
- `src_rd`  out  1: source read strobe. Data is valid on `src_data` the next cycle.
- `src_data`  in  9: palette word, G[8:6] R[5:3] B[2:0].
- `A`  out  3: VCE register select.
- `D_out`  out  8: write data. The top level drives the VCE `D` bus when `D_oe` is high.
- `D_oe`  out  1: data output enable.
- `RD_n`  out  1: tied high, because the loader never reads.
- `WR_n`  out  1: active-low write strobe.
- `CS_n`  out  1: active-low chip select.

## Operation
- FSM states: IDLE, ADDR_LO, ADDR_HI, FETCH, WAIT_DATA, DATA_LO, DATA_HI, DONE.
- IDLE:
  - `start` sets `busy`, clears the entry counter, and moves to ADDR_LO.
  - `start` is ignored while not in IDLE.
- ADDR_LO: writes A=2, D=START_ADDR[7:0].
- ADDR_HI: writes A=3, D={7'b0, START_ADDR[8]}.
- FETCH: `src_rd`=1 and `src_addr`=count for one cycle.
- WAIT_DATA: latches `src_data` into a 9-bit hold register.
- DATA_LO: writes A=4, D=hold[7:0].
- DATA_HI: writes A=5, D={7'b0, hold[8]}. The VCE auto-increments CTA on this write.
- After DATA_HI:
  - If count==NUM_ENTRIES-1, go to DONE.
  - Otherwise increment count and return to FETCH.
- DONE: `done`=1 for one cycle, `busy` drops, and the FSM returns to IDLE.
- Each write state runs the same three-phase transaction:
  - SETUP: waits while `bus_gnt`=0. A, D_out, D_oe=1, CS_n=0, WR_n=1. Lasts 1 cycle once granted.
  - STROBE: WR_n=0 for STROBE_CYCLES cycles.
  - RECOVER: WR_n=1 for STROBE_CYCLES cycles, with A, D, CS_n and D_oe held.
  - At the end of RECOVER, CS_n=1 and D_oe=0 for the transition cycle into the next state.
- Grant is sampled only in SETUP. Deasserting `bus_gnt` mid-transaction does not abort it.
- CTA wraps modulo 512 inside the VCE. The loader does not check START_ADDR+NUM_ENTRIES overflow, so wrap is the defined behaviour.
- Reset mid-load:
  - All outputs return to reset values on the next edge. A partial CRAM write may have occurred; this is accepted.
  - No `done` is produced.

## Timing
- Reset values:
  - Strobes and selects high: RD_n=1, WR_n=1, CS_n=1.
  - Everything else 0: busy, done, bus_req, src_rd, src_addr, A, D_out, D_oe.
- `busy` and `bus_req` rise the cycle after `start`.
- With continuous grant:
  - Write transaction: W = 2*STROBE_CYCLES + 2 cycles, including the deselect cycle.
  - Total from start to `done`: 1 + 2W + NUM_ENTRIES*(2 + 2W) cycles.
  - At defaults (W=14): 1 + 28 + 512*30 = 15389 cycles.
- A, D_out and CS_n are stable throughout every cycle in which WR_n=0.
- No two WR_n low pulses are ever separated by fewer than STROBE_CYCLES+1 high cycles.

## Structure
- Shared package `vce_pkg`:
  - Register index constants VCE_CR=0, VCE_CTA_LO=2, VCE_CTA_HI=3, VCE_CTW_LO=4, VCE_CTW_HI=5.
  - Loader state enum.
  - Typedef `cram_word_t` (logic [8:0]).
- One sub-module, `vce_bus_write`, implements the SETUP/STROBE/RECOVER engine.
  - Inputs: req, addr, data, bus_gnt.
  - Outputs: ack pulse and the bus pins.
  - The top-level FSM sequences it.

## Test plan
- Defaults with a behavioural VCE attached. Source ROM holds i^9'h155; start:
  - After `done`, CRAM[k] == k^9'h155 for all 512 entries.
  - Cycle count from start to `done` is 15389.
- START_ADDR=9'h1FE, NUM_ENTRIES=4, ROM = 9'h101, 9'h0AA, 9'h1FF, 9'h003:
  - CRAM[1FE]=101, CRAM[1FF]=0AA, CRAM[000]=1FF, CRAM[001]=003 (wrap).
  - CRAM[002] is untouched.
- Hold `bus_gnt`=0 for 40 cycles at the second write's SETUP:
  - WR_n stays high and A=3 is held.
  - The write proceeds once granted, and the final CRAM contents match.
- Pulse `start` again at cycle 100 of a load:
  - It is ignored; there is exactly one `done`.
- Assert `reset` during the STROBE phase of entry 10:
  - Next cycle WR_n=1, CS_n=1, D_oe=0, busy=0.
  - No `done` pulse.
  - A fresh start then completes correctly.
- Bus checker over all runs:
  - Every WR_n low interval lasts ≥3 clocks, and so does every high interval between writes.
  - A and D are constant while WR_n=0.
  - RD_n is never low.

Source files
------------

// File: rtl/vce_pkg.sv
// Shared definitions for the VCE palette loader: register indices,
// colour RAM word type and the state encodings of both FSMs.
package vce_pkg;

    localparam logic [2:0] VCE_CR     = 3'd0;
    localparam logic [2:0] VCE_CTA_LO = 3'd2;
    localparam logic [2:0] VCE_CTA_HI = 3'd3;
    localparam logic [2:0] VCE_CTW_LO = 3'd4;
    localparam logic [2:0] VCE_CTW_HI = 3'd5;

    // Palette word layout: G[8:6] R[5:3] B[2:0]
    typedef logic [8:0] cram_word_t;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_ADDR_LO,
        LD_ADDR_HI,
        LD_FETCH,
        LD_WAIT_DATA,
        LD_DATA_LO,
        LD_DATA_HI,
        LD_DONE
    } ld_state_t;

    typedef enum logic [1:0] {
        BW_IDLE,
        BW_STROBE,
        BW_RECOVER,
        BW_DESEL
    } bw_state_t;

    // Upper byte of a 9-bit value as the VCE expects it on the high register.
    function automatic logic [7:0] hi_byte(input cram_word_t w);
        return {7'b0, w[8]};
    endfunction

endpackage

// File: rtl/vce_bus_write.sv
// Single VCE MMIO write engine: SETUP (waits for grant), STROBE with
// WR_n low, RECOVER with WR_n high, then one deselect cycle with ack.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// BW_IDLE    | no write; while req is high this is the SETUP phase
// BW_STROBE  | WR_n low, counting STROBE_CYCLES down to terminal count
// BW_RECOVER | WR_n high, selects and data held, counting down again
// BW_DESEL   | CS_n high, D_oe low, ack pulse to the sequencer
module vce_bus_write
    import vce_pkg::*;
#(
    parameter int STROBE_CYCLES = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic [2:0] addr,
    input  logic [7:0] data,
    input  logic       bus_gnt,
    output logic       ack,
    output logic [2:0] A,
    output logic [7:0] D_out,
    output logic       D_oe,
    output logic       WR_n,
    output logic       CS_n
);

    localparam int CW = $clog2(STROBE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_CYCLES - 1);

    bw_state_t     state;
    bw_state_t     state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    // State and phase timer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BW_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Phase sequencing; grant only matters while waiting in SETUP.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            BW_IDLE: begin
                if (req && bus_gnt) begin
                    state_nx = BW_STROBE;
                    cnt_nx   = CNT_LOAD;
                end
            end
            BW_STROBE: begin
                if (cnt == '0) begin
                    state_nx = BW_RECOVER;
                    cnt_nx   = CNT_LOAD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            BW_RECOVER: begin
                if (cnt == '0) begin
                    state_nx = BW_DESEL;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            BW_DESEL: begin
                state_nx = BW_IDLE;
            end
            default: begin
                state_nx = BW_IDLE;
            end
        endcase
    end

    // Bus pin decode; A and D follow the request for the whole transaction.
    always_comb begin
        ack   = 1'b0;
        A     = 3'd0;
        D_out = 8'd0;
        D_oe  = 1'b0;
        WR_n  = 1'b1;
        CS_n  = 1'b1;
        case (state)
            BW_IDLE: begin
                if (req) begin
                    A     = addr;
                    D_out = data;
                    D_oe  = 1'b1;
                    CS_n  = 1'b0;
                end
            end
            BW_STROBE: begin
                A     = addr;
                D_out = data;
                D_oe  = 1'b1;
                CS_n  = 1'b0;
                WR_n  = 1'b0;
            end
            BW_RECOVER: begin
                A     = addr;
                D_out = data;
                D_oe  = 1'b1;
                CS_n  = 1'b0;
            end
            BW_DESEL: begin
                A     = addr;
                D_out = data;
                ack   = 1'b1;
            end
            default: begin
                ack = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/vce_palette_loader.sv
// Boot-time palette loader: streams a palette from a synchronous source
// memory into VCE colour RAM via CTA low/high then CTW low/high per entry.
//
// state        | meaning
// -------------+---------------------------------------------------------
// LD_IDLE      | waiting for start
// LD_ADDR_LO   | write CTA low byte with START_ADDR[7:0]
// LD_ADDR_HI   | write CTA high bit with START_ADDR[8]
// LD_FETCH     | source read of entry `count`
// LD_WAIT_DATA | capture source word into hold register
// LD_DATA_LO   | write CTW low byte
// LD_DATA_HI   | write CTW high bit; VCE auto-increments CTA
// LD_DONE      | one-cycle done pulse
module vce_palette_loader
    import vce_pkg::*;
#(
    parameter int         STROBE_CYCLES = 6,
    parameter int         NUM_ENTRIES   = 512,
    parameter logic [8:0] START_ADDR    = 9'h000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [8:0] src_addr,
    output logic       src_rd,
    input  logic [8:0] src_data,
    output logic [2:0] A,
    output logic [7:0] D_out,
    output logic       D_oe,
    output logic       RD_n,
    output logic       WR_n,
    output logic       CS_n
);

    localparam logic [8:0] LAST_IDX = 9'(NUM_ENTRIES - 1);

    ld_state_t  state;
    ld_state_t  state_nx;
    logic [8:0] count;
    cram_word_t hold;
    logic       wr_req;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Entry counter and source word hold register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            hold  <= '0;
        end else begin
            if (state == LD_IDLE && start) begin
                count <= '0;
            end else if (state == LD_DATA_HI && wr_ack && count != LAST_IDX) begin
                count <= count + 1'b1;
            end
            if (state == LD_WAIT_DATA) begin
                hold <= src_data;
            end
        end
    end

    // Next-state logic; write states advance on the engine's ack.
    always_comb begin
        state_nx = state;
        case (state)
            LD_IDLE:      if (start)  state_nx = LD_ADDR_LO;
            LD_ADDR_LO:   if (wr_ack) state_nx = LD_ADDR_HI;
            LD_ADDR_HI:   if (wr_ack) state_nx = LD_FETCH;
            LD_FETCH:                 state_nx = LD_WAIT_DATA;
            LD_WAIT_DATA:             state_nx = LD_DATA_LO;
            LD_DATA_LO:   if (wr_ack) state_nx = LD_DATA_HI;
            LD_DATA_HI: begin
                if (wr_ack) begin
                    state_nx = (count == LAST_IDX) ? LD_DONE : LD_FETCH;
                end
            end
            LD_DONE:                  state_nx = LD_IDLE;
            default:                  state_nx = LD_IDLE;
        endcase
    end

    // Status, source read and write-request decode.
    always_comb begin
        busy     = (state != LD_IDLE) && (state != LD_DONE);
        bus_req  = busy;
        done     = (state == LD_DONE);
        src_rd   = (state == LD_FETCH);
        src_addr = (state == LD_FETCH) ? count : 9'd0;
        wr_req   = 1'b0;
        wr_addr  = VCE_CR;
        wr_data  = 8'd0;
        case (state)
            LD_ADDR_LO: begin
                wr_req  = 1'b1;
                wr_addr = VCE_CTA_LO;
                wr_data = START_ADDR[7:0];
            end
            LD_ADDR_HI: begin
                wr_req  = 1'b1;
                wr_addr = VCE_CTA_HI;
                wr_data = hi_byte(START_ADDR);
            end
            LD_DATA_LO: begin
                wr_req  = 1'b1;
                wr_addr = VCE_CTW_LO;
                wr_data = hold[7:0];
            end
            LD_DATA_HI: begin
                wr_req  = 1'b1;
                wr_addr = VCE_CTW_HI;
                wr_data = hi_byte(hold);
            end
            default: begin
                wr_req = 1'b0;
            end
        endcase
    end

    assign RD_n = 1'b1;

    vce_bus_write #(
        .STROBE_CYCLES (STROBE_CYCLES)
    ) u_bus_write (
        .clock   (clock),
        .reset   (reset),
        .req     (wr_req),
        .addr    (wr_addr),
        .data    (wr_data),
        .bus_gnt (bus_gnt),
        .ack     (wr_ack),
        .A       (A),
        .D_out   (D_out),
        .D_oe    (D_oe),
        .WR_n    (WR_n),
        .CS_n    (CS_n)
    );

endmodule

// File: tb/tb_vce_palette_loader.sv
// Bench for vce_palette_loader: instance 0 uses defaults, instance 1 loads
// four entries starting at 1FE. Each has a behavioural VCE and source ROM.
module tb_vce_palette_loader;

    localparam int         STROBE = 6;
    localparam logic [8:0] SENT   = 9'h0F0;

    logic       clock;
    logic       reset    [2];
    logic       start    [2];
    logic       busy     [2];
    logic       done     [2];
    logic       bus_req  [2];
    logic       bus_gnt  [2];
    logic [8:0] src_addr [2];
    logic       src_rd   [2];
    logic [8:0] src_data [2];
    logic [2:0] A        [2];
    logic [7:0] D_out    [2];
    logic       D_oe     [2];
    logic       RD_n     [2];
    logic       WR_n     [2];
    logic       CS_n     [2];

    logic [8:0] rom  [2][512];
    logic [8:0] cram [2][512];
    logic [8:0] cta  [2];
    logic [7:0] lo_b [2];
    logic       wr_q [2];
    logic       vce_clr [2];
    int         nwr  [2];
    int         done_cnt [2];
    int         lo_len [2];
    int         hi_len [2];
    logic       seen [2];
    logic [2:0] a_hold [2];
    logic [7:0] d_hold [2];
    int         viol;
    int         cyc;
    int         checks;
    int         failures;

    typedef struct {
        logic [8:0] rom_word;
        logic [8:0] cram_idx;
        logic [8:0] exp;
    } vec_t;
    vec_t tbl [5];

    vce_palette_loader u_def (
        .clock (clock), .reset (reset[0]), .start (start[0]), .busy (busy[0]),
        .done (done[0]), .bus_req (bus_req[0]), .bus_gnt (bus_gnt[0]),
        .src_addr (src_addr[0]), .src_rd (src_rd[0]), .src_data (src_data[0]),
        .A (A[0]), .D_out (D_out[0]), .D_oe (D_oe[0]), .RD_n (RD_n[0]),
        .WR_n (WR_n[0]), .CS_n (CS_n[0])
    );

    vce_palette_loader #(
        .STROBE_CYCLES (STROBE), .NUM_ENTRIES (4), .START_ADDR (9'h1FE)
    ) u_wrap (
        .clock (clock), .reset (reset[1]), .start (start[1]), .busy (busy[1]),
        .done (done[1]), .bus_req (bus_req[1]), .bus_gnt (bus_gnt[1]),
        .src_addr (src_addr[1]), .src_rd (src_rd[1]), .src_data (src_data[1]),
        .A (A[1]), .D_out (D_out[1]), .D_oe (D_oe[1]), .RD_n (RD_n[1]),
        .WR_n (WR_n[1]), .CS_n (CS_n[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural VCE: register write committed when WR_n rises under CS_n.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (vce_clr[i]) begin
                for (int k = 0; k < 512; k++) cram[i][k] <= SENT;
                cta[i]  <= '0;
                lo_b[i] <= '0;
                nwr[i]  <= 0;
                wr_q[i] <= 1'b1;
            end else begin
                wr_q[i] <= WR_n[i];
                if (!wr_q[i] && WR_n[i] && !CS_n[i]) begin
                    case (A[i])
                        3'd2: cta[i][7:0] <= D_out[i];
                        3'd3: cta[i][8]   <= D_out[i][0];
                        3'd4: lo_b[i]     <= D_out[i];
                        3'd5: begin
                            cram[i][cta[i]] <= {D_out[i][0], lo_b[i]};
                            cta[i] <= cta[i] + 9'd1;
                            nwr[i] <= nwr[i] + 1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Source ROM, done counter and bus-timing checker.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (src_rd[i]) src_data[i] <= rom[i][src_addr[i]];
            if (reset[i]) begin
                lo_len[i] <= 0;
                hi_len[i] <= 0;
                seen[i]   <= 1'b0;
            end else if (!WR_n[i]) begin
                if (lo_len[i] == 0) begin
                    if (seen[i] && hi_len[i] < STROBE + 1) viol <= viol + 1;
                    a_hold[i] <= A[i];
                    d_hold[i] <= D_out[i];
                end else if (A[i] != a_hold[i] || D_out[i] != d_hold[i]) begin
                    viol <= viol + 1;
                end
                if (CS_n[i]) viol <= viol + 1;
                lo_len[i] <= lo_len[i] + 1;
            end else begin
                if (lo_len[i] != 0) begin
                    if (lo_len[i] != STROBE) viol <= viol + 1;
                    seen[i]   <= 1'b1;
                    hi_len[i] <= 1;
                end else begin
                    hi_len[i] <= hi_len[i] + 1;
                end
                lo_len[i] <= 0;
            end
            if (RD_n[i] !== 1'b1 && !reset[i]) viol <= viol + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(negedge clock);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, output int t);
        t = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (done[i] === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        int t0;
        int t;
        int n;
        int bad;
        int dc;

        checks   = 0;
        failures = 0;
        tbl[0] = '{9'h101, 9'h1FE, 9'h101};
        tbl[1] = '{9'h0AA, 9'h1FF, 9'h0AA};
        tbl[2] = '{9'h1FF, 9'h000, 9'h1FF};
        tbl[3] = '{9'h003, 9'h001, 9'h003};
        tbl[4] = '{9'h000, 9'h002, SENT};

        for (int i = 0; i < 2; i++) begin
            reset[i]   = 1'b1;
            start[i]   = 1'b0;
            bus_gnt[i] = 1'b1;
            vce_clr[i] = 1'b1;
        end
        for (int k = 0; k < 512; k++) begin
            rom[0][k] = 9'(k);
            rom[1][k] = 9'd0;
        end
        for (int r = 0; r < 4; r++) rom[1][r] = tbl[r].rom_word;

        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_state_%0d", i),
                32'({busy[i], done[i], bus_req[i], src_rd[i], src_addr[i], A[i],
                     D_out[i], D_oe[i], RD_n[i], WR_n[i], CS_n[i]}), 32'h7);
        end
        for (int i = 0; i < 2; i++) begin
            reset[i]   = 1'b0;
            vce_clr[i] = 1'b0;
        end
        @(negedge clock);

        // Wrapping load with grant withheld at the second write's SETUP.
        t0 = cyc;
        pulse_start(1);
        chk("busy_rise", 32'({busy[1], bus_req[1]}), 32'h3);
        n = 0;
        while (WR_n[1] !== 1'b0 && n < 50) begin @(negedge clock); n++; end
        bus_gnt[1] = 1'b0;
        n = 0;
        while (!(A[1] === 3'd3 && CS_n[1] === 1'b0) && n < 100) begin @(negedge clock); n++; end
        chk("gnt_setup_reached", 32'(A[1]), 32'd3);
        bad = 0;
        repeat (40) begin
            @(negedge clock);
            if (WR_n[1] !== 1'b1 || A[1] !== 3'd3 || CS_n[1] !== 1'b0) bad++;
        end
        chk("gnt_hold", 32'(bad), 32'd0);
        bus_gnt[1] = 1'b1;
        wait_done(1, 400, t);
        chk("wrap_cycles", 32'(t - t0), 32'd189);
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("cram_wrap_%03h", tbl[r].cram_idx),
                32'(cram[1][tbl[r].cram_idx]), 32'(tbl[r].exp));
        end
        chk("wrap_writes", 32'(nwr[1]), 32'd4);

        // Second start during a load is ignored.
        @(negedge clock);
        dc = done_cnt[1];
        t0 = cyc;
        pulse_start(1);
        repeat (98) @(negedge clock);
        pulse_start(1);
        wait_done(1, 400, t);
        chk("restart_cycles", 32'(t - t0), 32'd149);
        repeat (200) @(negedge clock);
        chk("single_done", 32'(done_cnt[1] - dc), 32'd1);
        chk("restart_idle", 32'({busy[1], bus_req[1]}), 32'd0);

        // Reset during the STROBE phase of entry 10.
        pulse_start(0);
        n = 0;
        while (!(src_rd[0] === 1'b1 && src_addr[0] === 9'd10) && n < 2000) begin @(negedge clock); n++; end
        n = 0;
        while (WR_n[0] !== 1'b0 && n < 50) begin @(negedge clock); n++; end
        chk("rst_entry10_strobe", 32'({A[0], WR_n[0]}), 32'({3'd4, 1'b0}));
        repeat (2) @(negedge clock);
        dc = done_cnt[0];
        reset[0] = 1'b1;
        @(negedge clock);
        chk("rst_outputs", 32'({WR_n[0], CS_n[0], D_oe[0], busy[0], done[0]}), 32'b11000);
        reset[0] = 1'b0;
        repeat (60) @(negedge clock);
        chk("rst_no_done", 32'(done_cnt[0] - dc), 32'd0);
        chk("rst_idle", 32'({busy[0], bus_req[0], CS_n[0]}), 32'b001);

        // Fresh full-size load after the reset.
        vce_clr[0] = 1'b1;
        @(negedge clock);
        vce_clr[0] = 1'b0;
        for (int k = 0; k < 512; k++) rom[0][k] = 9'(k) ^ 9'h155;
        @(negedge clock);
        t0 = cyc;
        pulse_start(0);
        wait_done(0, 16000, t);
        chk("full_cycles", 32'(t - t0), 32'd15389);
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (cram[0][k] !== (9'(k) ^ 9'h155)) bad++;
        end
        chk("cram_full_mismatches", 32'(bad), 32'd0);
        chk("full_writes", 32'(nwr[0]), 32'd512);
        repeat (5) @(negedge clock);

        chk("bus_rule_violations", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
